// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 serial receiver feeding a first-word-fall-through byte FIFO.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   i_rx              serial line, idle high, asynchronous to clk
//   o_rdata/o_rvalid  FIFO head byte and not-empty flag
//   i_rready          pop request, honoured when o_rvalid is high
//   o_level           number of bytes stored (0..FIFO_DEPTH)
//   o_frame_err       one-cycle pulse when a stop bit is sampled low
//   o_overflow        sticky flag, set when a byte is dropped on a full FIFO
module uart_rx_capture #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_rx,
   output logic [7:0]                    o_rdata,
   output logic                          o_rvalid,
   input  logic                          i_rready,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_frame_err,
   output logic                          o_overflow
);
   localparam int DIV  = CLK_FREQ_HZ / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_DIV  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   state_t state, state_n;
   logic rx_m, rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [7:0] sh, sh_n;
   logic push, ferr_n, pop, accept;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m        <= 1'b1;
         rx_s        <= 1'b1;
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         sh          <= '0;
         o_frame_err <= 1'b0;
      end else begin
         rx_m        <= i_rx;
         rx_s        <= rx_m;
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         sh          <= sh_n;
         o_frame_err <= ferr_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      push    = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            cnt_n = cnt + 1'b1;
            if (cnt == CNT_HALF) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            cnt_n = cnt + 1'b1;
            if (cnt == CNT_DIV) begin
               cnt_n = '0;
               sh_n  = {rx_s, sh[7:1]};
               idx_n = idx + 1'b1;
               if (idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            cnt_n = cnt + 1'b1;
            if (cnt == CNT_DIV) begin
               cnt_n   = '0;
               push    = rx_s;
               ferr_n  = !rx_s;
               state_n = rx_s ? IDLE : BREAK;
            end
         end
         BREAK: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign o_rvalid = (o_level != '0);
   assign pop      = o_rvalid & i_rready;
   assign accept   = push & ((o_level != FULL) | pop);
   assign o_rdata  = o_rvalid ? mem[rp] : 8'h00;
   always_ff @(posedge clk) begin
      if (accept) mem[wp] <= sh;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wp         <= '0;
         rp         <= '0;
         o_level    <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (accept) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         if (accept && !pop) o_level <= o_level + 1'b1;
         else if (pop && !accept) o_level <= o_level - 1'b1;
         if (push && !accept) o_overflow <= 1'b1;
      end
   end
endmodule

// File: doc/uart_rx_capture.md
# uart_rx_capture

Bench-side serial receiver that consumes the core's `o_uart_tx` line and turns it into a stream of bytes. It recovers 8N1 frames at a fixed baud rate and buffers the decoded bytes in a small FIFO with a ready/valid read port. It flags framing errors and overflow, so self-checking benches can compare console output against expected strings. The block is synthesizable and sits directly downstream of the SoC UART transmitter, both in simulation and on FPGA loopback rigs.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 50_000_000: frequency of `clk` in Hz.
- `BAUD_RATE`, default 115200: line rate.
- `FIFO_DEPTH`, default 8: byte buffer depth; must be a power of two, ≥2.
- Derived values:
  - DIV = CLK_FREQ_HZ / BAUD_RATE (truncated; must be ≥4).
  - HALF = DIV / 2 (truncated).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset: synchronous, active-high.
- `i_rx`  in  1  serial line; idle high; asynchronous to `clk`.
- `o_rdata`  out  8  byte at the FIFO head; valid while `o_rvalid` is high.
- `o_rvalid`  out  1  FIFO not empty.
- `i_rready`  in  1  pop request; a pop occurs when `o_rvalid & i_rready`.
- `o_level`  out  $clog2(FIFO_DEPTH)+1  number of bytes stored.
- `o_frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `o_overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full; cleared only by `rst`.

## Operation
- **Input synchronizer**
  - `i_rx` passes through two flops to give rx_s. Both flops reset to 1.
  - All decisions use rx_s.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. Supporting registers:
  - bit counter cnt, width $clog2(DIV);
  - bit index, 0..7;
  - shift register.
- **IDLE:** cnt=0. If rx_s==0, go to START.
- **START:** cnt increments each cycle. When cnt==HALF-1:
  - if rx_s==0, go to DATA with cnt=0 and index=0;
  - otherwise go to IDLE (glitch rejected; nothing is reported).
- **DATA:** when cnt==DIV-1:
  - shift rx_s in at the MSB, shifting right, so the byte is LSB-first on the wire;
  - set cnt=0 and increment the index;
  - after the 8th sample, go to STOP.
- **STOP:** when cnt==DIV-1:
  - rx_s==1: push the byte into the FIFO and go to IDLE;
  - rx_s==0: pulse `o_frame_err`, discard the byte, and go to BREAK.
- **BREAK:** wait for rx_s==1, then go to IDLE. This prevents a held-low line from retriggering frames.
- **FIFO push/pop rules**
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `o_overflow` is set.
  - A simultaneous push and pop leaves `o_level` unchanged.
  - Pointers wrap modulo FIFO_DEPTH. `o_level` ranges 0..FIFO_DEPTH.
- **Output behaviour**
  - The FIFO is first-word-fall-through: `o_rdata` shows the head entry combinationally from storage.
  - `o_rdata` is don't-care while `o_rvalid` is low.
- **Reset** (one `rst` cycle suffices, including mid-frame):
  - FSM goes to IDLE; pointers and level are cleared;
  - `o_rvalid`=0, `o_level`=0, `o_frame_err`=0, `o_overflow`=0, `o_rdata`=0;
  - any partially received byte is discarded.

## Timing
- **Sample points.** Let T be the first cycle in which rx_s==0 while in IDLE. Then:
  - start bit verified at T+HALF;
  - data bit k (k=0..7) sampled at T+HALF+(k+1)·DIV;
  - stop bit sampled at T+HALF+9·DIV.
- **Input latency:** 2 cycles from `i_rx` to rx_s.
- **Push latency:** the push happens at the stop-sample edge. `o_rvalid` and `o_level` update in the following cycle.
- **Frame-error timing:** `o_frame_err` is high for exactly the cycle after the stop-sample edge.
- **Pop latency:** `o_level` decrements in the cycle after the pop edge. The next entry appears on `o_rdata` in the same cycle.
- **Back-to-back frames:** a new start edge may be detected in the first IDLE cycle after STOP, so the block accepts back-to-back frames with no idle gap.
- **Overflow timing:** `o_overflow` rises in the cycle after the dropped push.

## Test plan
All scenarios use CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000, FIFO_DEPTH=4, which gives DIV=10 and HALF=5. The bench drives 10 clocks per bit.

1. **Single byte:** send 0x55 with `i_rready`=0.
   - `o_rvalid` rises 2+5+90+1 cycles after the `i_rx` falling edge, with `o_rdata`=0x55 and `o_level`=1.
   - Assert `i_rready` for 1 cycle: `o_rvalid`=0 and `o_level`=0 on the next cycle.
2. **Back-to-back stream:** send 0x00, 0xFF, 0xA5, 0x3C with no idle gap.
   - Popping returns exactly that order.
   - `o_frame_err` is never asserted.
3. **Overflow:** send 5 bytes 0x01..0x05 with `i_rready`=0.
   - `o_level`=4 and `o_overflow`=1 after the 5th stop sample.
   - Pops return 0x01..0x04.
   - `o_overflow` remains 1 until `rst`.
4. **Push+pop while full:** with the FIFO full, hold `i_rready`=1 across the 5th stop-sample edge.
   - The byte is accepted, `o_level` stays 4, and `o_overflow` stays 0.
5. **Framing error and glitch rejection:**
   - Send 0x41 with the stop bit low for 30 cycles: one `o_frame_err` pulse, no push. The FSM stays in BREAK until the line goes high, then the next valid 0x42 is received correctly.
   - A separate 3-cycle low glitch produces no push and no error.
6. **Reset mid-frame:** assert `rst` for one cycle during data bit 4 of a frame.
   - All outputs read 0 the next cycle.
   - The remaining bits produce no byte.
   - A subsequent 0x7E is received correctly.
